// File: rtl/lcv_mul_acc_pipe_if.sv
// Operand/result stream bundle for lcv_mul_acc_pipe: valid/ready in, valid/ready out.
interface lcv_mul_acc_pipe_if #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 40,
  parameter int NUM_ACC   = 4
);
  localparam int SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [1:0]                  in_op;
  logic [SEL_W-1:0]            in_sel;
  logic signed [IN_WIDTH-1:0]  in_a;
  logic signed [IN_WIDTH-1:0]  in_b;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [SEL_W-1:0]            out_sel;
  logic signed [ACC_WIDTH-1:0] out_data;
  logic                        out_ovf;

  modport slave (
    input  in_valid, in_op, in_sel, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sel, out_data, out_ovf
  );

  modport master (
    output in_valid, in_op, in_sel, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sel, out_data, out_ovf
  );
endinterface

// File: rtl/lcv_mul_acc_pipe.sv
// Two-stage signed multiply-accumulate with NUM_ACC selectable accumulators.
// Define LCV_MUL_ACC_PIPE_SAT_EN to clamp overflowing MAC/MSU results instead of wrapping.
module lcv_mul_acc_pipe #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 40,
  parameter int NUM_ACC   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  lcv_mul_acc_pipe_if.slave  bus
);
  localparam int SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int PW    = 2 * IN_WIDTH;

  typedef enum logic [1:0] {OP_MAC = 2'd0, OP_MSU = 2'd1, OP_LOAD = 2'd2, OP_CLEAR = 2'd3} op_e;

  typedef struct packed {
    logic signed [ACC_WIDTH-1:0] p;
    op_e                         op;
    logic [SEL_W-1:0]            sel;
    logic                        last;
  } s1_t;

  if (ACC_WIDTH < PW) begin : g_width_chk
    $error("lcv_mul_acc_pipe: ACC_WIDTH must be >= 2*IN_WIDTH");
  end
  if (NUM_ACC < 1) begin : g_num_chk
    $error("lcv_mul_acc_pipe: NUM_ACC must be >= 1");
  end

  logic                        r_s1_vld;
  s1_t                         r_s1;
  logic signed [ACC_WIDTH-1:0] r_acc [NUM_ACC];
  logic [NUM_ACC-1:0]          r_ovf;
  logic                        r_out_vld;
  logic [SEL_W-1:0]            r_out_sel;
  logic signed [ACC_WIDTH-1:0] r_out_data;
  logic                        r_out_ovf;

  logic                        w_stall;
  logic signed [PW-1:0]        w_prod;
  logic [NUM_ACC-1:0]          w_hit;
  logic                        w_sel_ok;
  logic signed [ACC_WIDTH-1:0] w_acc_rd;
  logic                        w_ovf_rd;
  logic signed [ACC_WIDTH-1:0] w_base;
  logic                        w_base_ovf;
  logic signed [ACC_WIDTH-1:0] w_add;
  logic signed [ACC_WIDTH-1:0] w_sub;
  logic signed [ACC_WIDTH-1:0] w_raw;
  logic                        w_of;
  logic signed [ACC_WIDTH-1:0] w_new;
  logic                        w_new_ovf;
  logic                        w_emit;

  // A pending result nobody takes freezes the whole pipe, accumulators included.
  assign w_stall      = r_out_vld && !bus.out_ready;
  assign bus.in_ready = !w_stall;
  assign w_prod       = bus.in_a * bus.in_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
    end else if (!w_stall) begin
      r_s1_vld <= bus.in_valid;
      r_s1.p    <= ACC_WIDTH'(w_prod);
      r_s1.op   <= op_e'(bus.in_op);
      r_s1.sel  <= bus.in_sel;
      r_s1.last <= bus.in_last;
    end
  end

  // Out-of-range selects match no entry, so the beat simply evaporates.
  always_comb begin
    w_hit    = '0;
    w_sel_ok = 1'b0;
    w_acc_rd = '0;
    w_ovf_rd = 1'b0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (r_s1.sel == SEL_W'(i)) begin
        w_sel_ok = 1'b1;
        w_acc_rd = r_acc[i];
        w_ovf_rd = r_ovf[i];
        w_hit[i] = r_s1_vld && !w_stall;
      end
    end
  end

  always_comb begin
    w_base     = (r_s1.op == OP_LOAD || r_s1.op == OP_CLEAR) ? '0 : w_acc_rd;
    w_base_ovf = (r_s1.op == OP_LOAD || r_s1.op == OP_CLEAR) ? 1'b0 : w_ovf_rd;
    w_add      = w_base + r_s1.p;
    w_sub      = w_base - r_s1.p;
    w_raw      = '0;
    w_of       = 1'b0;
    case (r_s1.op)
      OP_MAC: begin
        w_raw = w_add;
        w_of  = (w_base[ACC_WIDTH-1] == r_s1.p[ACC_WIDTH-1]) &&
                (w_add[ACC_WIDTH-1]  != w_base[ACC_WIDTH-1]);
      end
      OP_MSU: begin
        w_raw = w_sub;
        w_of  = (w_base[ACC_WIDTH-1] != r_s1.p[ACC_WIDTH-1]) &&
                (w_sub[ACC_WIDTH-1]  != w_base[ACC_WIDTH-1]);
      end
      OP_LOAD:  w_raw = r_s1.p;
      default:  w_raw = '0;
    endcase
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
    // Overflow direction always follows the sign of the pre-op accumulator.
    if (w_of)
      w_new = w_base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      w_new = w_raw;
`else
    w_new = w_raw;
`endif
    w_new_ovf = w_base_ovf | w_of;
  end

  assign w_emit = r_s1_vld && w_sel_ok && r_s1.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (w_hit[i]) begin
          r_acc[i] <= r_s1.last ? '0 : w_new;
          r_ovf[i] <= r_s1.last ? 1'b0 : w_new_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_sel  <= '0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
    end else if (!w_stall) begin
      r_out_vld <= w_emit;
      if (w_emit) begin
        r_out_sel  <= r_s1.sel;
        r_out_data <= w_new;
        r_out_ovf  <= w_new_ovf;
      end
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.out_sel   = r_out_sel;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// Directed bench: default 40-bit/4-acc instance plus a 32-bit/3-acc instance for overflow and range cases.
module tb_lcv_mul_acc_pipe;
  localparam logic [1:0] MAC = 2'd0, MSU = 2'd1, LOAD = 2'd2, CLR = 2'd3;

`ifdef LCV_MUL_ACC_PIPE_SAT_EN
  localparam logic [63:0] E_3MAC = 64'h7FFF_FFFF;
  localparam logic [63:0] E_MSU  = 64'h4000_FFFE;
`else
  localparam logic [63:0] E_3MAC = 64'hBFFD_0003;
  localparam logic [63:0] E_MSU  = 64'h7FFE_0002;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lcv_mul_acc_pipe_if #(.IN_WIDTH(16), .ACC_WIDTH(40), .NUM_ACC(4)) if0 ();
  lcv_mul_acc_pipe_if #(.IN_WIDTH(16), .ACC_WIDTH(32), .NUM_ACC(3)) if1 ();

  lcv_mul_acc_pipe #(.IN_WIDTH(16), .ACC_WIDTH(40), .NUM_ACC(4)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  lcv_mul_acc_pipe #(.IN_WIDTH(16), .ACC_WIDTH(32), .NUM_ACC(3)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic [1:0] op, input logic [1:0] sel, input int a, input int b, input logic last);
    if0.in_valid = 1'b1; if0.in_op = op; if0.in_sel = sel;
    if0.in_a = 16'(a); if0.in_b = 16'(b); if0.in_last = last;
  endtask

  task automatic beat0(input logic [1:0] op, input logic [1:0] sel, input int a, input int b, input logic last);
    drv0(op, sel, a, b, last);
    tick();
  endtask

  task automatic beat1(input logic [1:0] op, input logic [1:0] sel, input int a, input int b, input logic last);
    if1.in_valid = 1'b1; if1.in_op = op; if1.in_sel = sel;
    if1.in_a = 16'(a); if1.in_b = 16'(b); if1.in_last = last;
    tick();
  endtask

  task automatic idle();
    if0.in_valid = 1'b0; if0.in_last = 1'b0;
    if1.in_valid = 1'b0; if1.in_last = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    if0.in_valid = 0; if0.in_op = 0; if0.in_sel = 0; if0.in_a = 0; if0.in_b = 0;
    if0.in_last = 0; if0.out_ready = 1;
    if1.in_valid = 0; if1.in_op = 0; if1.in_sel = 0; if1.in_a = 0; if1.in_b = 0;
    if1.in_last = 0; if1.out_ready = 1;
    tick(); tick();
    chk("rst_vld",   64'(if0.out_valid), 64'd0);
    chk("rst_data",  64'($unsigned(if0.out_data)), 64'd0);
    chk("rst_sel",   64'(if0.out_sel), 64'd0);
    chk("rst_ovf",   64'(if0.out_ovf), 64'd0);
    chk("rst_rdy",   64'(if0.in_ready), 64'd1);
    chk("rst_vld1",  64'(if1.out_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // 12 + 30 - 14 on sel 1
    beat0(LOAD, 2'd1, 3, 4, 1'b0);
    beat0(MAC,  2'd1, 5, 6, 1'b0);
    beat0(MSU,  2'd1, 2, 7, 1'b1);
    chk("t1_lat",  64'(if0.out_valid), 64'd0);
    idle();
    chk("t1_vld",  64'(if0.out_valid), 64'd1);
    chk("t1_data", 64'($unsigned(if0.out_data)), 64'd28);
    chk("t1_sel",  64'(if0.out_sel), 64'd1);
    chk("t1_ovf",  64'(if0.out_ovf), 64'd0);
    idle();
    chk("t1_drop", 64'(if0.out_valid), 64'd0);
    beat0(MAC, 2'd1, 1, 1, 1'b1);
    idle();
    chk("t1_zvld", 64'(if0.out_valid), 64'd1);
    chk("t1_zero", 64'($unsigned(if0.out_data)), 64'd1);
    idle();

    // interleaved sel 0 / sel 2
    for (int k = 0; k < 4; k++) begin
      beat0(MAC, 2'd0, 1, 1, k == 3);
      beat0(MAC, 2'd2, 1, 1, k == 3);
    end
    chk("t2_vld0",  64'(if0.out_valid), 64'd1);
    chk("t2_sel0",  64'(if0.out_sel), 64'd0);
    chk("t2_data0", 64'($unsigned(if0.out_data)), 64'd4);
    idle();
    chk("t2_vld2",  64'(if0.out_valid), 64'd1);
    chk("t2_sel2",  64'(if0.out_sel), 64'd2);
    chk("t2_data2", 64'($unsigned(if0.out_data)), 64'd4);
    idle();
    chk("t2_end",   64'(if0.out_valid), 64'd0);

    // back-pressure: 25 held, 6 and 1 queued behind it
    if0.out_ready = 1'b0;
    beat0(MAC, 2'd3, 5, 5, 1'b1);
    beat0(MAC, 2'd3, 2, 3, 1'b1);
    drv0(MAC, 2'd0, 1, 1, 1'b1);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_rdy",  64'(if0.in_ready), 64'd0);
      chk("t3_vld",  64'(if0.out_valid), 64'd1);
      chk("t3_hold", 64'($unsigned(if0.out_data)), 64'd25);
      tick();
    end
    if0.out_ready = 1'b1;
    #1;
    chk("t3_rel", 64'(if0.in_ready), 64'd1);
    tick();
    if0.in_valid = 1'b0;
    chk("t3_b_data", 64'($unsigned(if0.out_data)), 64'd6);
    chk("t3_b_sel",  64'(if0.out_sel), 64'd3);
    tick();
    chk("t3_c_vld",  64'(if0.out_valid), 64'd1);
    chk("t3_c_data", 64'($unsigned(if0.out_data)), 64'd1);
    chk("t3_c_sel",  64'(if0.out_sel), 64'd0);
    tick();
    chk("t3_end", 64'(if0.out_valid), 64'd0);

    // most-negative operand squared, and a negative result
    beat0(LOAD, 2'd0, -32768, -32768, 1'b1);
    idle();
    chk("t4_sq",     64'($unsigned(if0.out_data)), 64'h4000_0000);
    chk("t4_sq_ovf", 64'(if0.out_ovf), 64'd0);
    beat0(MSU, 2'd2, 3, 4, 1'b1);
    idle();
    chk("t4_neg", 64'($unsigned(if0.out_data)), 64'hFF_FFFF_FFF4);
    idle();

    // 32-bit accumulator: fits, overflows, sticky through MSU
    beat1(LOAD, 2'd1, 32767, 32767, 1'b0);
    beat1(MAC,  2'd1, 32767, 32767, 1'b1);
    idle();
    chk("t5_fit",     64'($unsigned(if1.out_data)), 64'h7FFE_0002);
    chk("t5_fit_ovf", 64'(if1.out_ovf), 64'd0);
    beat1(LOAD, 2'd1, 32767, 32767, 1'b0);
    beat1(MAC,  2'd1, 32767, 32767, 1'b0);
    beat1(MAC,  2'd1, 32767, 32767, 1'b1);
    idle();
    chk("t5_of",     64'($unsigned(if1.out_data)), E_3MAC);
    chk("t5_of_ovf", 64'(if1.out_ovf), 64'd1);
    beat1(LOAD, 2'd1, 32767, 32767, 1'b0);
    beat1(MAC,  2'd1, 32767, 32767, 1'b0);
    beat1(MAC,  2'd1, 32767, 32767, 1'b0);
    beat1(MSU,  2'd1, 32767, 32767, 1'b1);
    idle();
    chk("t5_msu",     64'($unsigned(if1.out_data)), E_MSU);
    chk("t5_msu_ovf", 64'(if1.out_ovf), 64'd1);
    beat1(MAC, 2'd1, 1, 1, 1'b1);
    idle();
    chk("t5_after",     64'($unsigned(if1.out_data)), 64'd1);
    chk("t5_after_ovf", 64'(if1.out_ovf), 64'd0);
    idle();

    // select beyond NUM_ACC is discarded
    beat1(LOAD, 2'd0, 7, 1, 1'b0);
    beat1(LOAD, 2'd3, 9, 9, 1'b1);
    chk("t6_none0", 64'(if1.out_valid), 64'd0);
    idle();
    chk("t6_none1", 64'(if1.out_valid), 64'd0);
    idle();
    chk("t6_none2", 64'(if1.out_valid), 64'd0);
    beat1(MAC, 2'd0, 0, 0, 1'b1);
    idle();
    chk("t6_keep_vld", 64'(if1.out_valid), 64'd1);
    chk("t6_keep",     64'($unsigned(if1.out_data)), 64'd7);
    idle();

    // reset with a last beat in flight
    beat0(MAC, 2'd2, 3, 3, 1'b0);
    beat0(MAC, 2'd2, 2, 2, 1'b1);
    if0.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_vld",  64'(if0.out_valid), 64'd0);
    chk("t7_rst_data", 64'($unsigned(if0.out_data)), 64'd0);
    tick();
    chk("t7_rst_vld2", 64'(if0.out_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("t7_post0", 64'(if0.out_valid), 64'd0);
    tick();
    chk("t7_post1", 64'(if0.out_valid), 64'd0);
    beat0(MAC, 2'd2, 0, 0, 1'b1);
    idle();
    chk("t7_acc_vld", 64'(if0.out_valid), 64'd1);
    chk("t7_acc",     64'($unsigned(if0.out_data)), 64'd0);
    beat0(CLR, 2'd2, 5, 5, 1'b1);
    idle();
    chk("t7_clr",     64'($unsigned(if0.out_data)), 64'd0);
    chk("t7_clr_ovf", 64'(if0.out_ovf), 64'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
